// File: rtl/pipe_stage_skid.sv
// Handshaked pipeline-stage register with a 2-entry skid buffer, flush, bubble insertion and stall counter.
// Latency: 1 cycle from in_valid/in_data to out_valid/out_data while empty; 1 payload/cycle sustained.
// Backpressure: out_ready=0 fills the skid entry; in_ready (registered) drops only when both entries are held.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-low reset
//   flush           synchronous kill of all held entries (priority over accept/drain)
//   in_valid/in_ready/in_data     upstream handshake and payload
//   out_valid/out_ready/out_data  downstream handshake and payload
//   occupancy       entries held (0, 1 or 2)
//   stall_cnt       saturating count of cycles with out_valid=1 && out_ready=0
module pipe_stage_skid #(
    parameter int                DATA_W         = 320,
    parameter logic [DATA_W-1:0] NOP_VALUE      = {DATA_W{1'b0}},
    parameter bit                ZERO_ON_BUBBLE = 1'b1,
    parameter int                CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    // The state encoding doubles as the occupancy count.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]        r_state;
    logic              r_in_rdy;
    logic [DATA_W-1:0] r_m_dat;     // main entry, drives out_data
    logic [DATA_W-1:0] r_s_dat;     // skid entry, catches the beat accepted while stalled
    logic [CNT_W-1:0]  r_stall_cnt;

    logic       w_accept;
    logic       w_drain;
    logic       w_stall;
    logic [1:0] w_state_nxt;
    logic       w_m_ld_in;
    logic       w_m_ld_s;
    logic       w_s_ld;

    assign w_accept = in_valid && r_in_rdy;
    assign w_drain  = (r_state != ST_EMPTY) && out_ready;
    assign w_stall  = (r_state != ST_EMPTY) && !out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_m_ld_in   = 1'b0;
        w_m_ld_s    = 1'b0;
        w_s_ld      = 1'b0;
        if (flush) begin
            // A drain this cycle still completes downstream; the accepted beat is dropped.
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_m_ld_in   = 1'b1;
                        w_state_nxt = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_drain) begin
                        w_m_ld_in = 1'b1;
                    end else if (w_accept) begin
                        w_s_ld      = 1'b1;
                        w_state_nxt = ST_FULL;
                    end else if (w_drain) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only a drain can happen.
                    if (w_drain) begin
                        w_m_ld_s    = 1'b1;
                        w_state_nxt = ST_ONE;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_EMPTY;
            r_in_rdy    <= 1'b1;
            r_m_dat     <= NOP_VALUE;
            r_s_dat     <= {DATA_W{1'b0}};
            r_stall_cnt <= {CNT_W{1'b0}};
        end else begin
            r_state  <= w_state_nxt;
            // Registered from next state so in_ready has no path from out_ready.
            r_in_rdy <= (w_state_nxt != ST_FULL);
            if (w_m_ld_in) begin
                r_m_dat <= in_data;
            end else if (w_m_ld_s) begin
                r_m_dat <= r_s_dat;
            end
            if (w_s_ld) begin
                r_s_dat <= in_data;
            end
            // Counted on the pre-flush view of out_valid; never wraps.
            if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign in_ready  = r_in_rdy;
    assign out_valid = (r_state != ST_EMPTY);
    assign occupancy = r_state;
    assign stall_cnt = r_stall_cnt;
    // Bubble: either present the NOP payload or keep showing the last main-entry value.
    assign out_data  = (ZERO_ON_BUBBLE && (r_state == ST_EMPTY)) ? NOP_VALUE : r_m_dat;

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

    localparam int          DW  = 16;
    localparam logic [15:0] NOP = 16'hDEAD;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_ready;

    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [2:0]    stall_cnt;

    logic          h_in_ready;
    logic          h_out_valid;
    logic [DW-1:0] h_out_data;
    logic [1:0]    h_occupancy;
    logic [2:0]    h_stall_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    pipe_stage_skid #(.DATA_W(DW), .NOP_VALUE(NOP), .ZERO_ON_BUBBLE(1'b1), .CNT_W(3)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    // Same stimulus, hold-last-value bubble mode.
    pipe_stage_skid #(.DATA_W(DW), .NOP_VALUE(NOP), .ZERO_ON_BUBBLE(1'b0), .CNT_W(3)) u_hold (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(h_in_ready), .in_data(in_data),
        .out_valid(h_out_valid), .out_ready(out_ready), .out_data(h_out_data),
        .occupancy(h_occupancy), .stall_cnt(h_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          iv;
        logic [DW-1:0] d;
        logic          ordy;
        logic          fl;
        logic          eov;
        logic [DW-1:0] eod;
        logic [1:0]    eocc;
        logic          eir;
        logic [2:0]    est;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        rst       = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic chk_main(input string nm, input logic ov, input logic [DW-1:0] od,
                            input logic [1:0] occ, input logic ir, input logic [2:0] st);
        chk({nm, ".out_valid"}, 32'(out_valid), 32'(ov));
        chk({nm, ".out_data"},  32'(out_data),  32'(od));
        chk({nm, ".occupancy"}, 32'(occupancy), 32'(occ));
        chk({nm, ".in_ready"},  32'(in_ready),  32'(ir));
        chk({nm, ".stall_cnt"}, 32'(stall_cnt), 32'(st));
    endtask

    logic [DW-1:0] q[$];
    int            m_cnt;
    logic          m_acc;
    logic          m_drn;

    initial begin
        //        iv    d         ordy  fl  | eov   eod       occ   ir    stall
        vecs[0]  = '{1'b1, 16'h00A1, 1'b0, 1'b0, 1'b1, 16'h00A1, 2'd1, 1'b1, 3'd0};
        vecs[1]  = '{1'b1, 16'h00B2, 1'b0, 1'b0, 1'b1, 16'h00A1, 2'd2, 1'b0, 3'd1};
        vecs[2]  = '{1'b1, 16'h00C3, 1'b0, 1'b0, 1'b1, 16'h00A1, 2'd2, 1'b0, 3'd2};
        vecs[3]  = '{1'b1, 16'h00C3, 1'b0, 1'b0, 1'b1, 16'h00A1, 2'd2, 1'b0, 3'd3};
        vecs[4]  = '{1'b1, 16'h00C3, 1'b1, 1'b0, 1'b1, 16'h00B2, 2'd1, 1'b1, 3'd3};
        vecs[5]  = '{1'b1, 16'h00C3, 1'b1, 1'b0, 1'b1, 16'h00C3, 2'd1, 1'b1, 3'd3};
        vecs[6]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, NOP,      2'd0, 1'b1, 3'd3};
        vecs[7]  = '{1'b1, 16'h0011, 1'b0, 1'b0, 1'b1, 16'h0011, 2'd1, 1'b1, 3'd3};
        vecs[8]  = '{1'b1, 16'h0022, 1'b0, 1'b0, 1'b1, 16'h0011, 2'd2, 1'b0, 3'd4};
        vecs[9]  = '{1'b1, 16'h0033, 1'b0, 1'b1, 1'b0, NOP,      2'd0, 1'b1, 3'd5};
        vecs[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, NOP,      2'd0, 1'b1, 3'd5};
        vecs[11] = '{1'b1, 16'h0044, 1'b0, 1'b1, 1'b0, NOP,      2'd0, 1'b1, 3'd5};
        vecs[12] = '{1'b1, 16'h0055, 1'b1, 1'b0, 1'b1, 16'h0055, 2'd1, 1'b1, 3'd5};
        vecs[13] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0055, 2'd1, 1'b1, 3'd6};
        vecs[14] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0055, 2'd1, 1'b1, 3'd7};
        vecs[15] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0055, 2'd1, 1'b1, 3'd7};
        vecs[16] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, NOP,      2'd0, 1'b1, 3'd7};

        // Reset state
        do_reset();
        chk_main("reset", 1'b0, NOP, 2'd0, 1'b1, 3'd0);

        // Backpressure, flush collisions and stall counting
        for (int i = 0; i < 17; i++) begin
            in_valid  = vecs[i].iv;
            in_data   = vecs[i].d;
            out_ready = vecs[i].ordy;
            flush     = vecs[i].fl;
            step();
            chk_main($sformatf("vec%0d", i), vecs[i].eov, vecs[i].eod,
                     vecs[i].eocc, vecs[i].eir, vecs[i].est);
        end
        flush = 1'b0;

        // Asynchronous reset while FULL: takes effect with no clock edge
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_data   = 16'h0AAA;
        step();
        in_data = 16'h0BBB;
        step();
        chk("midrst.pre_occ", 32'(occupancy), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        chk_main("midrst", 1'b0, NOP, 2'd0, 1'b1, 3'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step();
        chk_main("midrst.after", 1'b0, NOP, 2'd0, 1'b1, 3'd0);

        // Streaming 1..100, one cycle lag, no gaps
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            in_data = 16'(i);
            step();
            chk($sformatf("stream%0d.valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("stream%0d.data", i),  32'(out_data),  32'(i));
        end
        in_valid = 1'b0;
        step();
        chk_main("stream.end", 1'b0, NOP, 2'd0, 1'b1, 3'd0);
        chk("hold.out_data",  32'(h_out_data),  32'd100);
        chk("hold.out_valid", 32'(h_out_valid), 32'd0);
        chk("hold.occupancy", 32'(h_occupancy), 32'd0);
        chk("hold.in_ready",  32'(h_in_ready),  32'd1);
        chk("hold.stall_cnt", 32'(h_stall_cnt), 32'd0);

        // Saturation of a 3-bit stall counter with stable held data
        do_reset();
        in_valid = 1'b1;
        in_data  = 16'h0077;
        step();
        in_valid = 1'b0;
        in_data  = 16'h1234;
        chk("sat.load", 32'(stall_cnt), 32'd0);
        for (int k = 1; k <= 20; k++) begin
            step();
            chk($sformatf("sat%0d.cnt", k),  32'(stall_cnt), 32'((k < 7) ? k : 7));
            chk($sformatf("sat%0d.data", k), 32'(out_data),  32'h0077);
            chk($sformatf("sat%0d.vld", k),  32'(out_valid), 32'd1);
        end

        // Random valid/ready/flush against a queue scoreboard
        do_reset();
        q.delete();
        m_cnt = 0;
        for (int c = 0; c < 10000; c++) begin
            chk("rnd.out_valid", 32'(out_valid), 32'(q.size() != 0));
            chk("rnd.occupancy", 32'(occupancy), 32'(q.size()));
            chk("rnd.in_ready",  32'(in_ready),  32'(q.size() != 2));
            chk("rnd.out_data",  32'(out_data),  32'((q.size() != 0) ? q[0] : NOP));
            chk("rnd.stall_cnt", 32'(stall_cnt), 32'(m_cnt));
            if (n_fail > 50) break;

            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 31) == 0);
            in_data   = 16'($urandom_range(0, 65535));

            m_acc = in_valid && (q.size() != 2);
            m_drn = (q.size() != 0) && out_ready;
            if ((q.size() != 0) && !out_ready && (m_cnt != 7)) m_cnt++;
            if (flush) begin
                q.delete();
            end else begin
                if (m_drn) void'(q.pop_front());
                if (m_acc) q.push_back(in_data);
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
